// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage of a 5-stage MIPS-style pipeline.
//
// Holds the program counter and the IF/ID pipeline register. Fetch is a
// single cycle: imem_addr is the PC register itself, and imem_rdata (a
// combinational read) is captured into IF/ID on the same edge the PC moves on.
//
// Next-PC priority, highest first:
//   reset > ex_branch_taken > stall > pc_src (decoded in ID).
// A taken EX branch or an ID redirect (J, JR, IRQ, EXC) flushes IF/ID to a
// bubble; there are no delay slots.
//
// Parameters:
//   RESET_PC  fetch address after reset (kernel space)
//   IRQ_VEC   interrupt handler entry
//   EXC_VEC   illegal-instruction handler entry
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   pc_src[2:0]       next-PC select from ID (0/1/6/7 seq, 2 J, 3 JR, 4 IRQ, 5 EXC)
//   id_jump_target    instr[25:0] of the J/JAL currently in ID
//   id_jr_target      forwarded rs for JR/JALR
//   ex_branch_taken   branch resolved taken in EX
//   ex_branch_target  branch destination from EX
//   stall             load-use hold from the hazard unit
//   imem_addr         current PC to instruction memory
//   imem_rdata        instruction memory read data
//   ifid_instr        IF/ID instruction
//   ifid_pc_plus4     IF/ID PC+4 (return address)
//   ifid_valid        IF/ID holds a real instruction
//   pc31              ifid_pc_plus4[31], kernel-mode flag for the decoder
//
// Optional build macro IF_PERF_CNT_EN adds saturating counters:
//   stall_cnt         cycles held by stall (not overridden by a branch)
//   flush_cnt         cycles in which IF/ID was flushed
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pc_src,
  input  logic [25:0] id_jump_target,
  input  logic [31:0] id_jr_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        pc31
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [2:0]  eff_src;
  logic [31:0] seq_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;

  always_comb begin
    // A bubble in ID carries no decoded control, so its pc_src is ignored.
    eff_src = ifid_valid_q ? pc_src : 3'd0;

    // Increment only the low 31 bits: user/kernel space (bit 31) can never
    // be crossed by falling through the end of a segment.
    seq_pc = {pc_q[31], pc_q[30:0] + 31'd4};

    redirect    = 1'b0;
    redirect_pc = seq_pc;
    case (eff_src)
      3'd2: begin
        redirect    = 1'b1;
        redirect_pc = {ifid_pc_plus4_q[31:28], id_jump_target, 2'b00};
      end
      3'd3: begin
        // User code may not JR into kernel space; bit 31 is only kept when
        // the current PC is already in kernel space.
        redirect    = 1'b1;
        redirect_pc = {pc_q[31] & id_jr_target[31], id_jr_target[30:0]};
      end
      3'd4: begin
        redirect    = 1'b1;
        redirect_pc = IRQ_VEC;
      end
      3'd5: begin
        redirect    = 1'b1;
        redirect_pc = EXC_VEC;
      end
      default: begin
        redirect    = 1'b0;
        redirect_pc = seq_pc;
      end
    endcase

    // A taken branch wins over stall; an ID redirect is held off by stall.
    flush = ex_branch_taken | (~stall & redirect);

    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;

    if (ex_branch_taken) begin
      pc_d            = ex_branch_target;
      ifid_instr_d    = 32'd0;
      ifid_pc_plus4_d = seq_pc;
      ifid_valid_d    = 1'b0;
    end else if (!stall) begin
      pc_d            = redirect_pc;
      ifid_pc_plus4_d = seq_pc;
      if (redirect) begin
        ifid_instr_d = 32'd0;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_instr_d = imem_rdata;
        ifid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign pc31          = ifid_pc_plus4_q[31];

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !ex_branch_taken && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // flush only feeds the performance counters.
  logic unused_flush;
  assign unused_flush = flush;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A reference model of the fetch stage is stepped alongside the DUT; each
// step pushes the model's expected outputs to exp_q and pops them after the
// clock edge for comparison. Directed scenarios (reset, sequential wrap, J,
// JR kernel protection, stall vs branch, plain stall, IRQ on a bubble,
// asynchronous reset mid-stall) are followed by a random phase.
// Build with +define+IF_PERF_CNT_EN to also check the counters.
// ----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [2:0]  pc_src = 3'd0;
  logic [25:0] id_jump_target = 26'd0;
  logic [31:0] id_jr_target = 32'd0;
  logic        ex_branch_taken = 1'b0;
  logic [31:0] ex_branch_target = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        pc31;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  if_stage #(
    .RESET_PC(RESET_PC),
    .IRQ_VEC (IRQ_VEC),
    .EXC_VEC (EXC_VEC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_src          (pc_src),
    .id_jump_target  (id_jump_target),
    .id_jr_target    (id_jr_target),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .stall           (stall),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .pc31            (pc31)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  // Instruction memory: a distinct word derived from every address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pp4, m_scnt, m_fcnt;
  logic        m_valid;

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
    m_scnt = 32'd0; m_fcnt = 32'd0;
  endtask

  // Next state from the current model state and the driven inputs.
  task automatic model_next();
    logic [2:0]  src;
    logic [31:0] seq;
    logic [31:0] npc;
    logic        is_redir;
    src = m_valid ? pc_src : 3'd0;
    seq = {m_pc[31], m_pc[30:0] + 31'd4};
    is_redir = (src >= 3'd2) && (src <= 3'd5);
    case (src)
      3'd2:    npc = {m_pp4[31:28], id_jump_target, 2'b00};
      3'd3:    npc = {m_pc[31] & id_jr_target[31], id_jr_target[30:0]};
      3'd4:    npc = IRQ_VEC;
      3'd5:    npc = EXC_VEC;
      default: npc = seq;
    endcase
    if (stall && !ex_branch_taken && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    if (ex_branch_taken || (!stall && is_redir)) begin
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    end
    if (ex_branch_taken) begin
      m_instr = 32'd0; m_valid = 1'b0; m_pp4 = seq; m_pc = ex_branch_target;
    end else if (!stall) begin
      m_pp4 = seq;
      if (is_redir) begin
        m_instr = 32'd0; m_valid = 1'b0;
      end else begin
        m_instr = mem_word(m_pc); m_valid = 1'b1;
      end
      m_pc = npc;
    end
  endtask

  task automatic push_expect();
    exp_q.push_back(m_pc);
    exp_q.push_back(m_instr);
    exp_q.push_back(m_pp4);
    exp_q.push_back({31'd0, m_valid});
    exp_q.push_back({31'd0, m_pp4[31]});
`ifdef IF_PERF_CNT_EN
    exp_q.push_back(m_scnt);
    exp_q.push_back(m_fcnt);
`endif
  endtask

  task automatic pop_compare();
    check("imem_addr",     imem_addr,            exp_q.pop_front());
    check("ifid_instr",    ifid_instr,           exp_q.pop_front());
    check("ifid_pc_plus4", ifid_pc_plus4,        exp_q.pop_front());
    check("ifid_valid",    {31'd0, ifid_valid},  exp_q.pop_front());
    check("pc31",          {31'd0, pc31},        exp_q.pop_front());
`ifdef IF_PERF_CNT_EN
    check("stall_cnt",     stall_cnt,            exp_q.pop_front());
    check("flush_cnt",     flush_cnt,            exp_q.pop_front());
`endif
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs (away from the edge), steps the model,
  // then compares 1 time unit after the rising edge.
  task automatic step(input logic [2:0] src, input logic [25:0] jt, input logic [31:0] jr,
                      input logic bt, input logic [31:0] btgt, input logic st);
    pc_src = src; id_jump_target = jt; id_jr_target = jr;
    ex_branch_taken = bt; ex_branch_target = btgt; stall = st;
    model_next();
    push_expect();
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  task automatic seq_step();
    step(3'd0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    step(3'd0, 26'd0, 32'd0, 1'b1, tgt, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] hold_pc, hold_instr, hold_pp4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt_before;
`endif

  initial begin
    // Reset held 3 cycles.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    push_expect(); pop_compare();
    reset = 1'b0;
    #1;
    check("rst_addr", imem_addr, 32'h8000_0000);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);

    // First edge fetches RESET_PC.
    seq_step();
    check("first_instr", ifid_instr, mem_word(32'h8000_0000));
    check("first_addr", imem_addr, 32'h8000_0004);

    // Plain stall for 3 cycles right after reset.
    hold_pc = imem_addr; hold_instr = ifid_instr; hold_pp4 = ifid_pc_plus4;
    repeat (3) step(3'd0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("stall_addr", imem_addr, hold_pc);
    check("stall_instr", ifid_instr, hold_instr);
    check("stall_pp4", ifid_pc_plus4, hold_pp4);
`ifdef IF_PERF_CNT_EN
    check("stall_cnt3", stall_cnt, 32'd3);
`endif

    // Stall also holds off an ID redirect.
    step(3'd2, 26'h3FF_FFFF, 32'd0, 1'b0, 32'd0, 1'b1);

    // Sequential increment keeps bit 31.
    branch_to(32'hFFFF_FFFC);
    seq_step();
    check("wrap_kernel", imem_addr, 32'h8000_0000);
    branch_to(32'h7FFF_FFFC);
    seq_step();
    check("wrap_user", imem_addr, 32'h0000_0000);

    // Jump.
    branch_to(32'h0040_0004);
    seq_step();
    step(3'd2, 26'h010_0010, 32'd0, 1'b0, 32'd0, 1'b0);
    check("j_addr", imem_addr, 32'h0040_0040);
    check("j_flush", ifid_instr, 32'd0);

    // JR protection from user and kernel space.
    branch_to(32'h0040_000C);
    seq_step();
    step(3'd3, 26'd0, 32'h8000_0100, 1'b0, 32'd0, 1'b0);
    check("jr_user", imem_addr, 32'h0000_0100);
    branch_to(32'h8000_000C);
    seq_step();
    step(3'd3, 26'd0, 32'h8000_0100, 1'b0, 32'd0, 1'b0);
    check("jr_kernel", imem_addr, 32'h8000_0100);

    // Branch overrides stall.
    seq_step();
`ifdef IF_PERF_CNT_EN
    fcnt_before = flush_cnt;
`endif
    step(3'd0, 26'd0, 32'd0, 1'b1, 32'h0040_0100, 1'b1);
    check("bvs_addr", imem_addr, 32'h0040_0100);
    check("bvs_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("bvs_fcnt", flush_cnt, fcnt_before + 32'd1);
`endif

    // IRQ on a bubble is ignored, then taken once ID is valid.
    step(3'd4, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("irq_bubble", imem_addr, 32'h0040_0104);
    step(3'd4, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("irq_addr", imem_addr, 32'h8000_0004);

    // EXC, and pc_src 6/7 act as sequential.
    seq_step();
    step(3'd5, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("exc_addr", imem_addr, 32'h8000_0008);
    seq_step();
    step(3'd6, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(3'd7, 26'd0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Asynchronous reset in the middle of a stall cycle.
    step(3'd0, 26'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    push_expect(); pop_compare();
    #1 reset = 1'b0;
    stall = 1'b0;
    seq_step();
    check("post_rst_instr", ifid_instr, mem_word(RESET_PC));

    // Random phase.
    for (int i = 0; i < 60; i++) begin
      step(3'($urandom_range(0, 7)), 26'($urandom), $urandom,
           ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 3) == 0));
    end

    if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the fetch address after reset (kernel mode).
REQ-002 SHALL have parameter IRQ_VEC, default 32'h8000_0004, the interrupt handler entry.
REQ-003 SHALL have parameter EXC_VEC, default 32'h8000_0008, the illegal-instruction handler entry.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk and reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port pc_src, input, 3, next-PC select from the ID-stage decoder (0/1 seq, 2 J, 3 JR, 4 IRQ, 5 EXC).
REQ-008 SHALL have port id_jump_target, input, 26, instr[25:0] of the J/JAL in ID.
REQ-009 SHALL have port id_jr_target, input, 32, forwarded rs value for JR/JALR.
REQ-010 SHALL have port ex_branch_taken, input, 1, branch resolved taken in EX.
REQ-011 SHALL have port ex_branch_target, input, 32, branch destination from EX.
REQ-012 SHALL have port stall, input, 1, load-use hold from the hazard unit.
REQ-013 SHALL have port imem_addr, output, 32, current PC to the instruction memory.
REQ-014 SHALL have port imem_rdata, input, 32, combinational instruction-memory read data.
REQ-015 SHALL have port ifid_instr, output, 32, IF/ID instruction register (OpCode/Funct source).
REQ-016 SHALL have port ifid_pc_plus4, output, 32, IF/ID PC+4 (return address).
REQ-017 SHALL have port ifid_valid, output, 1, IF/ID holds a real instruction.
REQ-018 SHALL have port pc31, output, 1, = ifid_pc_plus4[31], kernel-mode flag for the decoder.

Function
REQ-019 SHALL drive imem_addr directly from the PC register; fetch is single-cycle, and imem_rdata is captured into IF/ID on the same edge the PC advances.
REQ-020 SHALL compute seq = {pc[31], pc[30:0]+4}, so bit 31 never toggles by increment.
REQ-021 SHALL treat pc_src as 0 whenever ifid_valid=0.
REQ-022 SHALL select next PC with priority reset > ex_branch_taken > stall > pc_src.
REQ-023 SHALL load ex_branch_target on ex_branch_taken.
REQ-024 SHALL hold PC and IF/ID when stall is asserted alone.
REQ-025 SHALL map pc_src to next PC: 0/1/6/7 -> seq; 2 -> {ifid_pc_plus4[31:28], id_jump_target, 2'b00}; 3 -> {pc[31] & id_jr_target[31], id_jr_target[30:0]}; 4 -> IRQ_VEC; 5 -> EXC_VEC.
REQ-026 SHALL flush IF/ID (instr <= 0, valid <= 0, pc_plus4 <= seq) when ex_branch_taken=1 or the effective pc_src is 2, 3, 4 or 5; there are no delay slots.
REQ-027 SHALL otherwise load IF/ID with instr <= imem_rdata, pc_plus4 <= seq, valid <= 1.
REQ-028 SHALL let ex_branch_taken flush and redirect even when stall=1.

Reset
REQ-029 SHALL on reset, asynchronously and at any time including mid-stall or mid-redirect, set PC=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0 and counters=0.
REQ-030 SHALL fetch RESET_PC on the first edge after reset deasserts.

Configuration
REQ-031 SHALL, with IF_PERF_CNT_EN defined, add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-032 SHALL, with IF_PERF_CNT_EN defined, increment stall_cnt on every cycle where stall=1 and ex_branch_taken=0, and increment flush_cnt on every flush cycle.
REQ-033 SHALL, with IF_PERF_CNT_EN defined, saturate both counters at 32'hFFFF_FFFF.
REQ-034 SHALL, without IF_PERF_CNT_EN, have neither the counter ports nor the counter logic, with all other behaviour identical.

Verification
REQ-035 SHALL cover reset: hold 3 cycles, release -> imem_addr=0x80000000, ifid_valid=0; next edge -> ifid_instr=imem_rdata@0x80000000, imem_addr=0x80000004.
REQ-036 SHALL cover jump: ifid_pc_plus4=0x00400008, valid, pc_src=2, id_jump_target=26'h0100010 -> imem_addr=0x00400040, ifid_instr=0, ifid_valid=0.
REQ-037 SHALL cover JR protection: pc=0x00400010, pc_src=3, id_jr_target=0x80000100 -> imem_addr=0x00000100; repeat from pc=0x80000010 -> 0x80000100.
REQ-038 SHALL cover stall versus branch: stall=1 with ex_branch_taken=1 and target 0x00400100 -> imem_addr=0x00400100, IF/ID flushed, flush_cnt +1.
REQ-039 SHALL cover plain stall: stall=1 for 3 cycles -> imem_addr, ifid_instr and ifid_pc_plus4 unchanged, stall_cnt=3 (with IF_PERF_CNT_EN).
REQ-040 SHALL cover IRQ on a bubble: ifid_valid=0, pc_src=4 -> seq fetch and no redirect; then ifid_valid=1, pc_src=4 -> imem_addr=0x80000004, IF/ID flushed.
